// File: rtl/cache_plru_pkg.sv
// Shared types and tree helpers for the 8-way binary-tree pseudo-LRU.
// Latency: pure combinational functions. Backpressure: not applicable.
// Contents: plru_op_e, PLRU_BITS, plru_victim(bits), plru_promote(bits, way).
package cache_plru_pkg;

  localparam int WAYS      = 8;
  localparam int WAYS_REP  = 3;
  localparam int PLRU_BITS = WAYS - 1;

  typedef enum logic [1:0] {
    OP_TOUCH = 2'b00,
    OP_ALLOC = 2'b01,
    OP_PEEK  = 2'b10,
    OP_CLEAR = 2'b11
  } plru_op_e;

  typedef logic [PLRU_BITS-1:0] plru_bits_t;
  typedef logic [WAYS_REP-1:0]  plru_way_t;

  // Walk the tree: a set bit steers toward the lower-numbered subtree.
  function automatic plru_way_t plru_victim(input plru_bits_t b);
    plru_way_t v;
    if (b[0]) begin
      if (b[1]) v = b[3] ? 3'd0 : 3'd1;
      else      v = b[4] ? 3'd2 : 3'd3;
    end else begin
      if (b[2]) v = b[5] ? 3'd4 : 3'd5;
      else      v = b[6] ? 3'd6 : 3'd7;
    end
    return v;
  endfunction

  // Point every node on the accessed way's path away from it. The way
  // number bits map directly onto the required node values.
  function automatic plru_bits_t plru_promote(input plru_bits_t b, input plru_way_t w);
    plru_bits_t r;
    r    = b;
    r[0] = w[2];
    if (!w[2]) begin
      r[1] = w[1];
      if (!w[1]) r[3] = w[0];
      else       r[4] = w[0];
    end else begin
      r[2] = w[1];
      if (!w[1]) r[5] = w[0];
      else       r[6] = w[0];
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_plru_ctrl_if.sv
// Request/response bundle between the cache controller and the PLRU controller.
// Latency: wires only. Backpressure: req_ready on the request, none on the response.
// Ports: req_valid/req_ready/req_op/req_set/req_way, resp_valid/resp_way/resp_bits, init_done.
interface cache_plru_ctrl_if #(parameter int INDEX = 14);
  import cache_plru_pkg::*;

  logic       req_valid;
  logic       req_ready;
  plru_op_e   req_op;
  logic [INDEX-1:0] req_set;
  plru_way_t  req_way;
  logic       resp_valid;
  plru_way_t  resp_way;
  plru_bits_t resp_bits;
  logic       init_done;

  // Cache controller side.
  modport master (
    output req_valid, req_op, req_set, req_way,
    input  req_ready, resp_valid, resp_way, resp_bits, init_done
  );

  // PLRU controller side.
  modport slave (
    input  req_valid, req_op, req_set, req_way,
    output req_ready, resp_valid, resp_way, resp_bits, init_done
  );

endinterface

// File: rtl/cache_plru_ctrl_tree.sv
// Combinational next-state and victim logic for one 7-bit PLRU vector.
// Latency: zero cycles. Backpressure: not applicable.
// Ports: bits/op/way in, next_bits/victim out.
module plru_tree_update
  import cache_plru_pkg::*;
(
  input  plru_bits_t bits,
  input  plru_op_e   op,
  input  plru_way_t  way,
  output plru_bits_t next_bits,
  output plru_way_t  victim
);

  always_comb begin
    victim    = plru_victim(bits);
    next_bits = bits;
    case (op)
      OP_TOUCH: next_bits = plru_promote(bits, way);
      OP_ALLOC: next_bits = plru_promote(bits, victim);
      OP_PEEK:  next_bits = bits;
      OP_CLEAR: next_bits = '0;
      default:  next_bits = bits;
    endcase
  end

endmodule

// File: rtl/cache_plru_ctrl.sv
// Per-set PLRU state store: victim select / promote / clear, plus post-reset sweep.
// Latency: response registered one cycle after acceptance; SETS cycles of init after reset.
// Backpressure: req_ready low during the sweep only; the response cannot be stalled.
// Ports: clk, rst (sync, active-high), bus (slave modport of cache_plru_ctrl_if).
module cache_plru_ctrl
  import cache_plru_pkg::*;
#(
  parameter int SETS  = 16384,
  parameter int INDEX = $clog2(SETS)
) (
  input logic clk,
  input logic rst,
  cache_plru_ctrl_if.slave bus
);

  typedef enum logic {ST_INIT, ST_IDLE} state_e;

  state_e           state;
  logic [INDEX-1:0] sweep_ptr;
  plru_bits_t       mem [SETS];

  logic       ready_q;
  logic       init_done_q;
  logic       resp_valid_q;
  plru_way_t  resp_way_q;
  plru_bits_t resp_bits_q;

  logic       accept;
  plru_bits_t cur_bits;
  plru_bits_t next_bits;
  plru_way_t  victim;

  assign accept   = bus.req_valid && ready_q;
  // Combinational read; a same-set request on the next cycle sees the
  // value written at this edge without any forwarding.
  assign cur_bits = mem[bus.req_set];

  plru_tree_update u_tree (
    .bits      (cur_bits),
    .op        (bus.req_op),
    .way       (bus.req_way),
    .next_bits (next_bits),
    .victim    (victim)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_INIT;
      sweep_ptr    <= '0;
      ready_q      <= 1'b0;
      init_done_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_way_q   <= '0;
      resp_bits_q  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          resp_valid_q <= 1'b0;
          if (sweep_ptr == INDEX'(SETS - 1)) begin
            state       <= ST_IDLE;
            ready_q     <= 1'b1;
            init_done_q <= 1'b1;
          end else begin
            sweep_ptr <= sweep_ptr + INDEX'(1);
          end
        end
        ST_IDLE: begin
          resp_valid_q <= accept;
          if (accept) begin
            resp_way_q  <= (bus.req_op == OP_ALLOC || bus.req_op == OP_PEEK) ? victim : '0;
            resp_bits_q <= cur_bits;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Array has no reset of its own; the sweep is what clears it. Writes are
  // suppressed on reset cycles so a request colliding with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT)
        mem[sweep_ptr] <= '0;
      else if (accept)
        mem[bus.req_set] <= next_bits;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.init_done  = init_done_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_way   = resp_way_q;
  assign bus.resp_bits  = resp_bits_q;

endmodule

// File: tb/tb_cache_plru_ctrl.sv
module tb_cache_plru_ctrl;
  import cache_plru_pkg::*;

  localparam int SETS  = 16;
  localparam int INDEX = 4;

  typedef struct packed {
    plru_way_t  way;
    plru_bits_t bits;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exp_t       exp_q[$];
  plru_bits_t model_mem [SETS];
  plru_way_t  last_way;
  plru_bits_t last_bits;

  always #5 clk = ~clk;

  cache_plru_ctrl_if #(.INDEX(INDEX)) bus ();

  cache_plru_ctrl #(.SETS(SETS), .INDEX(INDEX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Scoreboard: every response strobe is matched against the oldest prediction.
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got way=%0d bits=%b, required no response", bus.resp_way, bus.resp_bits);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.resp_way !== e.way || bus.resp_bits !== e.bits) begin
          errors++;
          $display("FAIL resp: got way=%0d bits=%b, required way=%0d bits=%b",
                   bus.resp_way, bus.resp_bits, e.way, e.bits);
        end
      end
      last_way  = bus.resp_way;
      last_bits = bus.resp_bits;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) model_mem[i] = '0;
  endtask

  // Drive one request for one cycle (called at a negedge, returns at the next).
  task automatic send(input plru_op_e op, input int set, input int way);
    exp_t       e;
    plru_bits_t b;
    plru_way_t  v;
    b = model_mem[set];
    v = plru_victim(b);
    e.bits = b;
    e.way  = '0;
    case (op)
      OP_TOUCH: model_mem[set] = plru_promote(b, plru_way_t'(way));
      OP_ALLOC: begin e.way = v; model_mem[set] = plru_promote(b, v); end
      OP_PEEK:  e.way = v;
      OP_CLEAR: model_mem[set] = '0;
      default:  ;
    endcase
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_at_send: got %b, required 1", bus.req_ready);
    end
    exp_q.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_set   = INDEX'(set);
    bus.req_way   = plru_way_t'(way);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Deassert rst at a negedge and count cycles until req_ready.
  task automatic release_and_time(input string name);
    int cyc = 0;
    rst = 1'b0;
    while (bus.req_ready !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.resp_valid !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL %s_resp_in_sweep: got resp_valid=%b, required 0", name, bus.resp_valid);
      end
    end
    checks++;
    if (cyc != SETS) begin
      errors++;
      $display("FAIL %s_init_latency: got %0d cycles, required %0d", name, cyc, SETS);
    end
    checks++;
    if (bus.init_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_init_done: got %b, required 1", name, bus.init_done);
    end
    model_clear();
  endtask

  task automatic peek_all_zero(input string name);
    for (int s = 0; s < SETS; s++) send(OP_PEEK, s, 0);
    idle(1);
    drain();
    for (int s = 0; s < SETS; s++) begin
      checks++;
      if (model_mem[s] !== 7'b0) begin
        errors++;
        $display("FAIL %s_model_set%0d: got %b, required 0", name, s, model_mem[s]);
      end
    end
    checks++;
    if (last_way !== 3'd7 || last_bits !== 7'b0) begin
      errors++;
      $display("FAIL %s_cleared_peek: got way=%0d bits=%b, required way=7 bits=0", name, last_way, last_bits);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_TOUCH;
    bus.req_set   = '0;
    bus.req_way   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_way !== 3'd0 ||
        bus.resp_bits !== 7'd0 || bus.init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b way=%0d bits=%b done=%b, required all 0",
               bus.req_ready, bus.resp_valid, bus.resp_way, bus.resp_bits, bus.init_done);
    end
    release_and_time("reset");
    peek_all_zero("reset");
  endtask

  task automatic test_promotion_chain();
    for (int w = 0; w < 8; w++) send(OP_TOUCH, 3, w);
    send(OP_PEEK, 3, 5);
    idle(1);
    drain();
    checks++;
    if (last_way !== 3'd0 || last_bits !== 7'b1111111) begin
      errors++;
      $display("FAIL promotion_chain: got way=%0d bits=%b, required way=0 bits=1111111", last_way, last_bits);
    end
  endtask

  task automatic test_alloc_stream();
    int exp_ways [8] = '{7, 3, 5, 1, 6, 2, 4, 0};
    plru_way_t got [8];
    for (int i = 0; i < 8; i++) begin
      send(OP_ALLOC, 5, 0);
      checks++;
      if (bus.resp_valid !== 1'b1) begin
        errors++;
        $display("FAIL alloc_stream_vld%0d: got %b, required 1", i + 1, bus.resp_valid);
      end
      got[i] = bus.resp_way;
    end
    idle(1);
    drain();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== plru_way_t'(exp_ways[i])) begin
        errors++;
        $display("FAIL alloc_stream_way%0d: got %0d, required %0d", i, got[i], exp_ways[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    send(OP_TOUCH, 6, 7);
    send(OP_ALLOC, 6, 2);
    idle(1);
    drain();
    checks++;
    if (last_way !== 3'd3 || last_bits !== 7'b1000101) begin
      errors++;
      $display("FAIL back_to_back: got way=%0d bits=%b, required way=3 bits=1000101", last_way, last_bits);
    end
  endtask

  task automatic test_clear();
    send(OP_CLEAR, 3, 4);
    send(OP_PEEK, 3, 0);
    idle(1);
    drain();
    checks++;
    if (last_way !== 3'd7 || last_bits !== 7'b0) begin
      errors++;
      $display("FAIL clear_peek: got way=%0d bits=%b, required way=7 bits=0", last_way, last_bits);
    end
    // Neighbouring sets keep their traffic history; scoreboard holds the model values.
    send(OP_PEEK, 5, 0);
    send(OP_PEEK, 6, 0);
    idle(1);
    drain();
    checks++;
    if (last_bits === 7'b0) begin
      errors++;
      $display("FAIL clear_other_set: got bits=%b, required nonzero", last_bits);
    end
  endtask

  task automatic test_mid_reset();
    send(OP_TOUCH, 1, 2);
    send(OP_ALLOC, 2, 0);
    idle(1);
    drain();
    // Request presented on the same edge as rst: must be dropped.
    bus.req_valid = 1'b1;
    bus.req_op    = OP_TOUCH;
    bus.req_set   = INDEX'(4);
    bus.req_way   = 3'd1;
    rst = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreq_reset: got vld=%b rdy=%b, required 0 0", bus.resp_valid, bus.req_ready);
    end
    // Let the sweep run partway, then reset it again.
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL midsweep_quiet: got vld=%b rdy=%b, required 0 0", bus.resp_valid, bus.req_ready);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    release_and_time("midsweep");
    peek_all_zero("midsweep");
  endtask

  initial begin
    model_clear();
    test_reset();
    test_promotion_chain();
    test_alloc_stream();
    test_back_to_back();
    test_clear();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
